// File: rtl/thresholding_pkg.sv
// Shared types and helpers for the thresholding parameter loader.
//   loader_state_e : sequencer states
//   cf_of / t_of / addr_bits_of : derived sizes from the top-level parameters
//   thresh_addr    : byte address {cf, pe, t, 2'b00} of one threshold register
package thresholding_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_RESP,
    ST_DONE
  } loader_state_e;

  function automatic int cf_of(int c, int pe);
    return c / pe;
  endfunction

  function automatic int t_of(int n);
    return (1 << n) - 1;
  endfunction

  function automatic int addr_bits_of(int c, int pe, int n);
    return $clog2(c / pe) + $clog2(pe) + n + 2;
  endfunction

  // pe_bits is $clog2(PE); a zero-width field simply contributes no shift.
  // The cf field sits above pe/t, so when CF==1 it lands outside ADDR_BITS
  // and is dropped by the caller's truncation.
  function automatic logic [31:0] thresh_addr(int cf, int pe, int t, int n, int pe_bits);
    logic [31:0] a;
    a = 32'(cf);
    a = (a << pe_bits) | 32'(pe);
    a = (a << n) | 32'(t);
    return a << 2;
  endfunction

endpackage

// File: rtl/thresholding_addr_cnt.sv
// Cascaded threshold/PE/channel-fold counter.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : zero all fields
//   inc_i         : advance t, carrying into pe then cf
//   t_o/pe_o/cf_o : current position
//   last_o        : position is the final word (cf=CF-1, pe=PE-1, t=T-1)
module thresholding_addr_cnt #(
  parameter int N   = 2,
  parameter int PE  = 1,
  parameter int CF  = 1,
  parameter int TW  = 2,
  parameter int PEW = 1,
  parameter int CFW = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           inc_i,
  output logic [TW-1:0]  t_o,
  output logic [PEW-1:0] pe_o,
  output logic [CFW-1:0] cf_o,
  output logic           last_o
);

  localparam int T = (1 << N) - 1;

  logic [TW-1:0]  t_q, t_d;
  logic [PEW-1:0] pe_q, pe_d;
  logic [CFW-1:0] cf_q, cf_d;
  logic t_wrap, pe_wrap, cf_wrap;

  assign t_wrap  = (t_q == TW'(T - 1));
  assign pe_wrap = (pe_q == PEW'(PE - 1));
  assign cf_wrap = (cf_q == CFW'(CF - 1));
  assign last_o  = t_wrap && pe_wrap && cf_wrap;

  always_comb begin
    t_d  = t_q;
    pe_d = pe_q;
    cf_d = cf_q;
    if (clr_i) begin
      t_d  = '0;
      pe_d = '0;
      cf_d = '0;
    end else if (inc_i) begin
      if (!t_wrap) begin
        t_d = t_q + 1'b1;
      end else begin
        t_d = '0;
        if (!pe_wrap) begin
          pe_d = pe_q + 1'b1;
        end else begin
          pe_d = '0;
          cf_d = cf_wrap ? '0 : cf_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q  <= '0;
      pe_q <= '0;
      cf_q <= '0;
    end else begin
      t_q  <= t_d;
      pe_q <= pe_d;
      cf_q <= cf_d;
    end
  end

  assign t_o  = t_q;
  assign pe_o = pe_q;
  assign cf_o = cf_q;

endmodule

// File: rtl/thresholding_param_loader.sv
// Streams a threshold image into a thresholding adapter over AXI-Lite writes,
// one write per stream beat, walking cf -> pe -> t.
//   ap_clk, ap_rst_n      : clock, async active-low reset
//   start / busy / done   : load request, in-progress flag, completion pulse
//   err                   : sticky, set by any non-OKAY BRESP
//   s_axis_*              : threshold stream (data in bits [K-1:0])
//   m_axilite_AW*/W*/B*   : AXI-Lite write channels toward the adapter
// Every output comes from a register or from the state register alone.
module thresholding_param_loader
  import thresholding_pkg::*;
#(
  parameter int N      = 2,
  parameter int K      = 8,
  parameter int C      = 1,
  parameter int PE     = 1,
  parameter int SIGNED = 1,
  localparam int DW        = ((K + 7) / 8) * 8,
  localparam int ADDR_BITS = addr_bits_of(C, PE, N)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DW-1:0]        s_axis_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP
);

  localparam int CF  = cf_of(C, PE);
  localparam int TW  = N;
  localparam int PEB = $clog2(PE);
  localparam int PEW = (PE > 1) ? $clog2(PE) : 1;
  localparam int CFW = (CF > 1) ? $clog2(CF) : 1;

  if (C % PE != 0) begin : g_bad_pe
    $error("thresholding_param_loader: C must be a multiple of PE");
  end

  loader_state_e  state_q, state_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           err_q, err_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    ext;
  logic           cnt_clr, cnt_inc, cnt_last;
  logic [TW-1:0]  cnt_t;
  logic [PEW-1:0] cnt_pe;
  logic [CFW-1:0] cnt_cf;

  // Widen the K-bit threshold to 32 bits, sign- or zero-filled.
  for (genvar i = 0; i < 32; i++) begin : g_ext
    if (i < K) begin : g_bit
      assign ext[i] = s_axis_tdata[i];
    end else if (SIGNED != 0) begin : g_sx
      assign ext[i] = s_axis_tdata[K-1];
    end else begin : g_zx
      assign ext[i] = 1'b0;
    end
  end

  thresholding_addr_cnt #(
    .N(N), .PE(PE), .CF(CF), .TW(TW), .PEW(PEW), .CFW(CFW)
  ) u_cnt (
    .clk_i (ap_clk),
    .rst_ni(ap_rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .t_o   (cnt_t),
    .pe_o  (cnt_pe),
    .cf_o  (cnt_cf),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          cnt_clr = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (s_axis_tvalid) begin
          wdata_d   = ext;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A low valid doubles as that channel's "already accepted" flag.
        if (m_axilite_AWREADY) awvalid_d = 1'b0;
        if (m_axilite_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (m_axilite_BVALID) begin
          err_d   = err_q | (m_axilite_BRESP != 2'b00);
          cnt_inc = 1'b1;
          state_d = cnt_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
    end
  end

  // Counters only move in RESP, so the address is stable across ISSUE.
  assign m_axilite_AWADDR  = ADDR_BITS'(thresh_addr(32'(cnt_cf), 32'(cnt_pe), 32'(cnt_t), N, PEB));
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_WDATA   = wdata_q;
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = (state_q == ST_RESP);
  assign s_axis_tready     = (state_q == ST_FETCH);
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign err               = err_q;

endmodule
